// File: rtl/alu_led_pkg.sv
// ----------------------------------------------------------------------------
// alu_led_pkg
// Shared types and constants for the LED ALU sequencer.
//   state_e   : controller states (IDLE, ISSUE, WAIT)
//   OP_ADD    : ALU opcode for increment
//   OP_SUB    : ALU opcode for decrement
//   DEF_WIDTH : default accumulator / ALU data width
//   DEF_CNT_W : default completed-operation counter width
// ----------------------------------------------------------------------------
package alu_led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/alu_led_seq_if.sv
// ----------------------------------------------------------------------------
// alu_led_seq_if
// Bundle of request/ack handshakes, parallel load and ALU datapath signals.
//   master : requesters + ALU side (drives req_*, load, load_val, lamps)
//   slave  : sequencer side (drives opcode, accum, ack_*, busy, op_count)
// ----------------------------------------------------------------------------
interface alu_led_seq_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) ();

    logic             req_inc;
    logic             req_dec;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] lamps;
    logic             opcode;
    logic [WIDTH-1:0] accum;
    logic             ack_inc;
    logic             ack_dec;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output req_inc, req_dec, load, load_val, lamps,
        input  opcode, accum, ack_inc, ack_dec, busy, op_count
    );

    modport slave (
        input  req_inc, req_dec, load, load_val, lamps,
        output opcode, accum, ack_inc, ack_dec, busy, op_count
    );

endinterface

// File: rtl/alu_led_seq_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter with a registered last-grant pointer.
//   clk     : system clock
//   rst     : asynchronous active-low reset (pointer favours req[0])
//   req     : request vector, bit 0 = inc, bit 1 = dec
//   advance : a grant is being taken this cycle; pointer moves past winner
//   grant   : one-hot grant (combinational)
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr_q = 0 -> req[0] wins a tie, ptr_q = 1 -> req[1] wins a tie
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_led_seq.sv
// ----------------------------------------------------------------------------
// alu_led_seq
// Shares the single-bit-opcode LED inc/dec ALU between an increment and a
// decrement requester. Owns the accumulator, drives the ALU opcode/accum and
// captures the registered lamps result back into the accumulator.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : alu_led_seq_if.slave (req/ack handshakes, load, ALU datapath,
//         busy, op_count)
// Optional build macro ALU_LED_SAT_EN: saturate instead of wrapping; a grant
// that would wrap still acks but performs no ALU operation.
//
//   state | meaning
//   IDLE  | accept load or arbitrate requests
//   ISSUE | ack high, accum/opcode stable for the ALU to register lamps
//   WAIT  | capture lamps into accum, bump op_count
// ----------------------------------------------------------------------------
module alu_led_seq
    import alu_led_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    alu_led_seq_if.slave  bus
);

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] accum_q,    accum_d;
    logic             opcode_q,   opcode_d;
    logic             ack_inc_q,  ack_inc_d;
    logic             ack_dec_q,  ack_dec_d;
    logic             busy_q,     busy_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [1:0] req_vec;
    logic [1:0] grant;
    logic       ack_pending;
    logic       advance;

    assign req_vec     = {bus.req_dec, bus.req_inc};
    // The ack cycle of a saturated grant is spent in IDLE while the requester
    // still holds req; block arbitration for that cycle so it is not regranted.
    assign ack_pending = ack_inc_q | ack_dec_q;
    assign advance     = (state_q == IDLE) && !bus.load && !ack_pending
                         && (|req_vec);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vec),
        .advance (advance),
        .grant   (grant)
    );

`ifdef ALU_LED_SAT_EN
    logic sat_hit;
    assign sat_hit = (grant[0] && (&accum_q)) || (grant[1] && (accum_q == '0));
`endif

    always_comb begin
        state_d    = state_q;
        accum_d    = accum_q;
        opcode_d   = opcode_q;
        ack_inc_d  = 1'b0;
        ack_dec_d  = 1'b0;
        busy_d     = 1'b0;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    accum_d = bus.load_val;
                end else if (advance) begin
                    opcode_d  = grant[1] ? OP_SUB : OP_ADD;
                    ack_inc_d = grant[0];
                    ack_dec_d = grant[1];
                    state_d   = ISSUE;
                    busy_d    = 1'b1;
`ifdef ALU_LED_SAT_EN
                    if (sat_hit) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
                busy_d  = 1'b1;
            end
            WAIT: begin
                accum_d    = bus.lamps;
                op_count_d = op_count_q + 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            accum_q    <= '0;
            opcode_q   <= OP_ADD;
            ack_inc_q  <= 1'b0;
            ack_dec_q  <= 1'b0;
            busy_q     <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            accum_q    <= accum_d;
            opcode_q   <= opcode_d;
            ack_inc_q  <= ack_inc_d;
            ack_dec_q  <= ack_dec_d;
            busy_q     <= busy_d;
            op_count_q <= op_count_d;
        end
    end

    assign bus.accum    = accum_q;
    assign bus.opcode   = opcode_q;
    assign bus.ack_inc  = ack_inc_q;
    assign bus.ack_dec  = ack_dec_q;
    assign bus.busy     = busy_q;
    assign bus.op_count = op_count_q;

endmodule

// File: tb/tb_alu_led_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_led_seq
// Directed bench for alu_led_seq with a registered inc/dec ALU model on lamps.
// Build with ALU_LED_SAT_EN to exercise the saturating variant.
// ----------------------------------------------------------------------------
module tb_alu_led_seq;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    alu_led_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_led_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External ALU: registers accum +/- 1 every cycle
    always @(posedge clk) begin
        bus.lamps <= bus.opcode ? (bus.accum - 16'd1) : (bus.accum + 16'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.req_inc  = 1'b0;
        bus.req_dec  = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;

        // reset state
        step();
        step();
        chk("rst_accum",  32'(bus.accum),    32'h0);
        chk("rst_busy",   32'(bus.busy),     32'h0);
        chk("rst_ack",    32'({bus.ack_inc, bus.ack_dec}), 32'h0);
        chk("rst_opcode", 32'(bus.opcode),   32'h0);
        chk("rst_cnt",    32'(bus.op_count), 32'h0);
        rst = 1'b1;
        step();

        // single increment: ack at N+1, busy N+1..N+2, result at N+3
        bus.req_inc = 1'b1;
        step();
        chk("inc_ack",    32'(bus.ack_inc), 32'h1);
        chk("inc_busy1",  32'(bus.busy),    32'h1);
        chk("inc_opcode", 32'(bus.opcode),  32'h0);
        bus.req_inc = 1'b0;
        step();
        chk("inc_ack_off", 32'(bus.ack_inc), 32'h0);
        chk("inc_busy2",   32'(bus.busy),    32'h1);
        chk("inc_accum_w", 32'(bus.accum),   32'h0);
        step();
        exp_cnt = 1;
        chk("inc_accum", 32'(bus.accum),    32'h0001);
        chk("inc_idle",  32'(bus.busy),     32'h0);
        chk("inc_cnt",   32'(bus.op_count), 32'(exp_cnt));

        // load then decrement
        bus.load = 1'b1;
        bus.load_val = 16'h00FF;
        step();
        bus.load = 1'b0;
        chk("load_accum", 32'(bus.accum),    32'h00FF);
        chk("load_cnt",   32'(bus.op_count), 32'(exp_cnt));
        bus.req_dec = 1'b1;
        step();
        chk("dec_ack",    32'(bus.ack_dec), 32'h1);
        chk("dec_opcode", 32'(bus.opcode),  32'h1);
        bus.req_dec = 1'b0;
        step();
        step();
        exp_cnt = 2;
        chk("dec_accum", 32'(bus.accum),    32'h00FE);
        chk("dec_cnt",   32'(bus.op_count), 32'(exp_cnt));

        // both requests held: alternate inc, dec, inc, dec
        bus.req_inc = 1'b1;
        bus.req_dec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_ack_inc", 32'(bus.ack_inc), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_ack_dec", 32'(bus.ack_dec), (i % 2 == 0) ? 32'h0 : 32'h1);
            step();
            step();
            chk("rr_accum", 32'(bus.accum), (i % 2 == 0) ? 32'h00FF : 32'h00FE);
        end
        bus.req_inc = 1'b0;
        bus.req_dec = 1'b0;
        exp_cnt = 6;
        chk("rr_cnt", 32'(bus.op_count), 32'(exp_cnt));

        // all-ones increment
        bus.load = 1'b1;
        bus.load_val = 16'hFFFF;
        step();
        bus.load = 1'b0;
        bus.req_inc = 1'b1;
`ifdef ALU_LED_SAT_EN
        step();
        chk("sat_ack",  32'(bus.ack_inc), 32'h1);
        chk("sat_busy", 32'(bus.busy),    32'h0);
        bus.req_inc = 1'b0;
        step();
        chk("sat_busy2", 32'(bus.busy),     32'h0);
        chk("sat_accum", 32'(bus.accum),    32'hFFFF);
        chk("sat_cnt",   32'(bus.op_count), 32'(exp_cnt));
`else
        step();
        chk("wrap_ack", 32'(bus.ack_inc), 32'h1);
        bus.req_inc = 1'b0;
        step();
        step();
        exp_cnt = 7;
        chk("wrap_accum", 32'(bus.accum),    32'h0000);
        chk("wrap_cnt",   32'(bus.op_count), 32'(exp_cnt));
`endif

        // load during ISSUE is dropped, later IDLE load works
        bus.load = 1'b1;
        bus.load_val = 16'h0010;
        step();
        bus.load = 1'b0;
        bus.req_inc = 1'b1;
        step();
        chk("bl_ack", 32'(bus.ack_inc), 32'h1);
        bus.req_inc = 1'b0;
        bus.load = 1'b1;
        bus.load_val = 16'h1234;
        step();
        bus.load = 1'b0;
        chk("bl_ignored", 32'(bus.accum), 32'h0010);
        step();
        exp_cnt++;
        chk("bl_accum", 32'(bus.accum),    32'h0011);
        chk("bl_cnt",   32'(bus.op_count), 32'(exp_cnt));
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("bl_load_ok", 32'(bus.accum), 32'h1234);

        // reset during WAIT, held request re-served afterwards
        bus.req_dec = 1'b1;
        step();
        chk("rw_ack", 32'(bus.ack_dec), 32'h1);
        step();
        chk("rw_in_wait", 32'(bus.busy), 32'h1);
        rst = 1'b0;
        #1;
        chk("rw_accum", 32'(bus.accum), 32'h0);
        chk("rw_busy",  32'(bus.busy),  32'h0);
        chk("rw_ack0",  32'({bus.ack_inc, bus.ack_dec}), 32'h0);
        chk("rw_cnt",   32'(bus.op_count), 32'h0);
        step();
        rst = 1'b1;
        step();
        chk("rw2_ack",    32'(bus.ack_dec), 32'h1);
        chk("rw2_opcode", 32'(bus.opcode),  32'h1);
        bus.req_dec = 1'b0;
        step();
        step();
        chk("rw2_accum", 32'(bus.accum),    32'hFFFF);
        chk("rw2_cnt",   32'(bus.op_count), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
